// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one full-adder slice.
// It adds A + B + Cin one bit per clock, least significant bit first.
// Handshake: start is accepted in IDLE or DONE. busy stays high for WIDTH
// cycles. done pulses for one cycle when Sum/Carry take their new value.
// Sum/Carry are updated only on the completion edge and never show partial bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  // Bit counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, ps_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  logic             s_bit, c_nxt, last_bit, accept;
  logic [WIDTH-1:0] ps_nxt;

  // Full-adder slice working on the current low bits of the operand registers.
  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 sits at the LSB.
  assign ps_nxt   = (ps_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // Status outputs decode the registered state, so start has no combinational path to them.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. DONE lasts one cycle and can go straight back to SHIFT.
  always_comb begin
    // NOTE: the default comes first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, one bit per SHIFT cycle, result registered on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and partial-sum flops are reset too, so nothing stale survives an abort.
      a_q   <= '0;
      b_q   <= '0;
      ps_q  <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      c_q   <= Cin;
      ps_q  <= '0;
      cnt_q <= '0;
    end else if (state == SHIFT) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      c_q   <= c_nxt;
      ps_q  <= ps_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_bit) begin
        Sum   <= ps_nxt;
        Carry <= c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH = 8, 2 and 1.
// The driver decides when a start is accepted using only a timing model.
// On acceptance it pushes {Carry,Sum} = A+B+Cin and the cycle when done is due.
// One monitor per instance checks done, busy and the held result after every edge.
module tb_serial_adder;

  localparam int ND = 3;

  typedef struct {
    logic [8:0] val;
    int         due;
    int         k;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ND-1:0]      rst_v, start_v, cin_v, busy_v, done_v;
  logic [ND-1:0][7:0] a_v, b_v;
  logic [ND-1:0][8:0] obs_v;

  exp_t       sb [ND][$];
  logic [8:0] held [ND];
  int         next_free [ND];
  bit         mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int wd(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 2 : 1);
    logic [W-1:0] sum_w;
    logic         carry_w;

    serial_adder #(.WIDTH(W)) u_dut (
      .clk  (clk),
      .rst  (rst_v[g]),
      .start(start_v[g]),
      .A    (a_v[g][W-1:0]),
      .B    (b_v[g][W-1:0]),
      .Cin  (cin_v[g]),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .Sum  (sum_w),
      .Carry(carry_w)
    );
    assign obs_v[g] = 9'({carry_w, sum_w});

    // Monitor: runs just after each rising edge and compares against the scoreboard.
    always begin
      @(posedge clk);
      #1;
      if (mon_en) begin : mon
        logic exp_done, exp_busy;
        exp_t e;
        exp_done = (sb[g].size() > 0) && (sb[g][0].due == cyc);
        exp_busy = (sb[g].size() > 0) && (cyc >= sb[g][0].k) && (cyc < sb[g][0].k + W);
        check($sformatf("w%0d done", W), 32'(done_v[g]), 32'(exp_done));
        check($sformatf("w%0d busy", W), 32'(busy_v[g]), 32'(exp_busy));
        if (exp_done) begin
          e = sb[g].pop_front();
          held[g] = e.val;
        end
        check($sformatf("w%0d carry_sum", W), 32'(obs_v[g]), 32'(held[g]));
      end
    end
  end

  // Drives one cycle on instance d and updates the reference model.
  // The call starts at a falling edge. The inputs are sampled at the next rising edge (e).
  task automatic step(input int d, input bit st, input logic [7:0] a, input logic [7:0] b,
                      input bit cin, input bit r);
    int   w, e, s;
    exp_t x;
    w = wd(d);
    e = cyc + 1;
    rst_v[d]   = r;
    start_v[d] = st;
    a_v[d]     = a;
    b_v[d]     = b;
    cin_v[d]   = cin;
    if (r) begin
      sb[d].delete();
      held[d]      = '0;
      next_free[d] = e + 1;
    end else if (st && (e >= next_free[d])) begin
      s = int'(a & 8'((1 << w) - 1)) + int'(b & 8'((1 << w) - 1)) + int'(cin);
      x.val = 9'(s & ((1 << (w + 1)) - 1));
      x.due = e + w;
      x.k   = e;
      sb[d].push_back(x);
      next_free[d] = e + w + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) step(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    rst_v   = '1;
    start_v = '0;
    cin_v   = '0;
    a_v     = '0;
    b_v     = '0;
    for (int d = 0; d < ND; d++) begin
      held[d]      = '0;
      next_free[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset busy %0d", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset done %0d", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset carry_sum %0d", d), 32'(obs_v[d]), 32'd0);
    end
    rst_v  = '0;
    mon_en = 1'b1;

    // Zero operands, then the three directed vectors.
    step(0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0); idle(0, 10);
    step(0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0); idle(0, 9);
    step(0, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0); idle(0, 9);
    step(0, 1'b1, 8'h3C, 8'h42, 1'b0, 1'b0); idle(0, 9);

    // A second start during SHIFT must be ignored.
    step(0, 1'b1, 8'h3C, 8'h42, 1'b0, 1'b0); idle(0, 2);
    step(0, 1'b1, 8'h11, 8'h42, 1'b0, 1'b0); idle(0, 9);

    // With start held high, a new addition begins every WIDTH+1 cycles.
    repeat (30) step(0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    idle(0, 10);

    // Abort in mid-SHIFT. rst and start arrive together, and rst wins.
    step(0, 1'b1, 8'hC3, 8'h77, 1'b1, 1'b0); idle(0, 3);
    step(0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b1); idle(0, 12);

    // Random traffic with occasional resets.
    repeat (300)
      step(0, ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 39) == 0));
    idle(0, 10);

    // Exhaustive coverage of the narrow instances.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          step(1, 1'b1, 8'(a), 8'(b), 1'(c), 1'b0);
          idle(1, 2);
        end
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++) begin
          step(2, 1'b1, 8'(a), 8'(b), 1'(c), 1'b0);
          idle(2, 1);
        end
    repeat (5) @(negedge clk);

    for (int d = 0; d < ND; d++)
      check($sformatf("scoreboard drained %0d", d), 32'(sb[d].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
